// File: rtl/traffic_pkg.sv
// Shared types for the vehicle light / pedestrian signal path.
package traffic_pkg;

    typedef enum logic [2:0] {
        L_GREEN  = 3'b001,
        L_YELLOW = 3'b010,
        L_RED    = 3'b100
    } light_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_ARMED,
        P_WALK,
        P_CLEAR
    } ped_state_t;

    // True when exactly one of the three light bits is set.
    function automatic logic is_onehot3(input logic [2:0] code);
        return (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
    endfunction

endpackage

// File: rtl/ped_interval_timer.sv
// Down-counter shared by the WALK and CLEAR intervals; saturates at zero.
module ped_interval_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic             zero
);

    // Load has priority over decrement; decrement stops at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (dec && (value != '0)) begin
            value <= value - CNT_W'(1);
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian signal stage: latches requests, holds the vehicle phase at red,
// then runs a WALK interval followed by a flashing CLEAR interval.
module ped_signal_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned WALK_CYCLES  = 8,
    parameter int unsigned CLEAR_CYCLES = 6,
    parameter int unsigned FLASH_DIV    = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       dir,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic             veh_hold,
    output logic             ped_wait,
    output logic [CNT_W-1:0] remaining,
    output logic             fault
);

    localparam int unsigned FL_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

    ped_state_t       state;
    logic             btn_q;
    logic [FL_W-1:0]  flash_cnt;
    logic             rise;
    logic             is_red;
    logic             fault_cond;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;

    // Request edge, red detection, fault detection and the unregistered hold.
    always_comb begin
        rise       = ped_btn & ~btn_q;
        is_red     = (dir == L_RED);
        fault_cond = !is_onehot3(dir) ||
                     (((state == P_WALK) || (state == P_CLEAR)) && !is_red);
        veh_hold   = ((state == P_ARMED) && is_red) ||
                     (state == P_WALK) || (state == P_CLEAR);
    end

    // Interval timer control: load on interval entry, clear on fault.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        if (fault_cond) begin
            tmr_load = 1'b1;
        end else begin
            case (state)
                P_ARMED: begin
                    if (is_red) begin
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(WALK_CYCLES - 1);
                    end
                end
                P_WALK: begin
                    if (tmr_zero) begin
                        tmr_load = 1'b1;
                        tmr_val  = CNT_W'(CLEAR_CYCLES - 1);
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
                P_CLEAR: tmr_dec = 1'b1;
                default: ;
            endcase
        end
    end

    ped_interval_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .value    (remaining),
        .zero     (tmr_zero)
    );

    // Pedestrian FSM with registered lamp, request and fault outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= P_IDLE;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            ped_wait  <= 1'b0;
            fault     <= 1'b0;
            btn_q     <= 1'b0;
            flash_cnt <= '0;
        end else begin
            btn_q <= ped_btn;
            if (fault_cond) begin
                fault     <= 1'b1;
                state     <= P_IDLE;
                ped_wait  <= 1'b0;
                walk      <= 1'b0;
                dont_walk <= 1'b1;
                flash_cnt <= '0;
            end else begin
                case (state)
                    P_IDLE: begin
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                        if (!fault && (ped_wait || rise)) begin
                            state    <= P_ARMED;
                            ped_wait <= 1'b1;
                        end
                    end
                    P_ARMED: begin
                        if (is_red) begin
                            state     <= P_WALK;
                            walk      <= 1'b1;
                            dont_walk <= 1'b0;
                            ped_wait  <= 1'b0;
                        end
                    end
                    P_WALK: begin
                        if (tmr_zero) begin
                            state     <= P_CLEAR;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
                            flash_cnt <= '0;
                        end
                    end
                    P_CLEAR: begin
                        if (tmr_zero) begin
                            state     <= (ped_wait || rise) ? P_ARMED : P_IDLE;
                            ped_wait  <= ped_wait || rise;
                            dont_walk <= 1'b1;
                            flash_cnt <= '0;
                        end else begin
                            if (rise) begin
                                ped_wait <= 1'b1;
                            end
                            if (flash_cnt == FL_W'(FLASH_DIV - 1)) begin
                                flash_cnt <= '0;
                                dont_walk <= ~dont_walk;
                            end else begin
                                flash_cnt <= flash_cnt + FL_W'(1);
                            end
                        end
                    end
                    default: state <= P_IDLE;
                endcase
            end
        end
    end

endmodule
